// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_pkg
//  Purpose  : Shared RV32I encoding constants: encoder format codes, base
//             opcodes (common with the decoder's ImmGen/control) and the
//             immediate range limits for each instruction format.
//  Revision : 1.0  initial release
// ============================================================================
package rv_pkg;

  // Encoder format codes (in_fmt)
  localparam logic [2:0] FMT_I_ALU  = 3'd0;
  localparam logic [2:0] FMT_I_LOAD = 3'd1;
  localparam logic [2:0] FMT_I_JALR = 3'd2;
  localparam logic [2:0] FMT_S      = 3'd3;
  localparam logic [2:0] FMT_B      = 3'd4;
  localparam logic [2:0] FMT_J      = 3'd5;

  // Base opcodes
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Signed immediate limits. B and J limits are the largest even values
  // because bit 0 of a branch/jump offset is never encoded.
  localparam int IMM_IS_MIN = -2048;
  localparam int IMM_IS_MAX = 2047;
  localparam int IMM_B_MIN  = -4096;
  localparam int IMM_B_MAX  = 4094;
  localparam int IMM_J_MIN  = -1048576;
  localparam int IMM_J_MAX  = 1048574;

endpackage : rv_pkg
`default_nettype wire

// File: rtl/imm_pack.sv
`default_nettype none
// ============================================================================
//  Module   : imm_pack
//  Purpose  : Combinational RV32I packer. Scatters the immediate into the
//             I/S/B/J field layout and flags out-of-range immediates or an
//             illegal format code.
//  Ports    : fmt_i     format code (see rv_pkg)
//             rd_i, rs1_i, rs2_i, funct3_i  register / funct3 fields
//             imm_i     signed immediate (byte offset for B/J)
//             inst_o    encoded instruction (zero for an illegal format)
//             err_o     range violation or illegal format
//  Revision : 1.0  initial release
// ============================================================================
module imm_pack
  import rv_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic [2:0]       fmt_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [2:0]       funct3_i,
  input  logic [Width-1:0] imm_i,
  output logic [Width-1:0] inst_o,
  output logic             err_o
);

  logic signed [Width-1:0] imm_s;
  logic [31:0]             inst;
  logic [6:0]              i_op;
  logic [2:0]              i_f3;

  assign imm_s = $signed(imm_i);

  always_comb begin
    i_op = OP_IMM;
    i_f3 = funct3_i;
    if (fmt_i == FMT_I_LOAD) begin
      i_op = OP_LOAD;
    end else if (fmt_i == FMT_I_JALR) begin
      i_op = OP_JALR;
      i_f3 = 3'b000;  // JALR only defines funct3 = 000
    end
  end

  always_comb begin
    inst  = 32'd0;
    err_o = 1'b0;
    case (fmt_i)
      FMT_I_ALU, FMT_I_LOAD, FMT_I_JALR: begin
        inst  = {imm_i[11:0], rs1_i, i_f3, rd_i, i_op};
        err_o = (imm_s < IMM_IS_MIN) || (imm_s > IMM_IS_MAX);
      end
      FMT_S: begin
        inst  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_STORE};
        err_o = (imm_s < IMM_IS_MIN) || (imm_s > IMM_IS_MAX);
      end
      FMT_B: begin
        inst  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                 imm_i[4:1], imm_i[11], OP_BRANCH};
        err_o = (imm_s < IMM_B_MIN) || (imm_s > IMM_B_MAX) || imm_i[0];
      end
      FMT_J: begin
        inst  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OP_JAL};
        err_o = (imm_s < IMM_J_MIN) || (imm_s > IMM_J_MAX) || imm_i[0];
      end
      default: begin
        inst  = 32'd0;
        err_o = 1'b1;
      end
    endcase
  end

  assign inst_o = Width'(inst);

endmodule : imm_pack
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : imm_encoder
//  Purpose  : Streaming RV32I instruction encoder for the program loader.
//             One output register stage (latency 1), ready/valid on both
//             sides, sequential byte-address tagging and a saturating count
//             of erroneous words.
//  Ports    : clk, rst_n          clock, async active-low reset
//             addr_clr            return address counter to BaseAddr
//             in_valid/in_ready   input handshake
//             in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm  fields
//             out_valid/out_ready output handshake
//             out_inst, out_addr, out_err  presented word
//             err_count           saturating error count
//  Revision : 1.0  initial release
// ============================================================================
module imm_encoder
  import rv_pkg::*;
#(
  parameter int          Width     = 32,
  parameter int          AddrWidth = 10,
  parameter int unsigned BaseAddr  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 addr_clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_fmt,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [2:0]           in_funct3,
  input  logic [Width-1:0]     in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [Width-1:0]     out_inst,
  output logic [AddrWidth-1:0] out_addr,
  output logic                 out_err,
  output logic [7:0]           err_count
);

  localparam logic [AddrWidth-1:0] BASE = AddrWidth'(BaseAddr);

  logic                 valid_q, valid_d;
  logic [Width-1:0]     inst_q, inst_d;
  logic                 err_q, err_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [7:0]           errcnt_q, errcnt_d;

  logic [Width-1:0]     pack_inst;
  logic                 pack_err;
  logic                 in_hs;
  logic                 out_hs;

  imm_pack #(
    .Width (Width)
  ) u_pack (
    .fmt_i    (in_fmt),
    .rd_i     (in_rd),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .funct3_i (in_funct3),
    .imm_i    (in_imm),
    .inst_o   (pack_inst),
    .err_o    (pack_err)
  );

  // The stage can take a new word whenever it is empty or being drained.
  assign in_ready = !valid_q || out_ready;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = valid_q && out_ready;

  always_comb begin
    valid_d  = valid_q;
    inst_d   = inst_q;
    err_d    = err_q;
    addr_d   = addr_q;
    errcnt_d = errcnt_q;

    if (in_hs) begin
      valid_d = 1'b1;
      inst_d  = pack_inst;
      err_d   = pack_err;
    end else if (out_hs) begin
      valid_d = 1'b0;
    end

    // Counter tracks the address of the word on the output; it moves only
    // when that word is consumed. A clear wins over the increment.
    if (addr_clr) begin
      addr_d = BASE;
    end else if (out_hs) begin
      addr_d = addr_q + AddrWidth'(4);
    end

    if (out_hs && err_q && (errcnt_q != 8'hFF)) begin
      errcnt_d = errcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      inst_q   <= '0;
      err_q    <= 1'b0;
      addr_q   <= BASE;
      errcnt_q <= 8'd0;
    end else begin
      valid_q  <= valid_d;
      inst_q   <= inst_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_inst  = inst_q;
  assign out_err   = err_q;
  assign out_addr  = addr_q;
  assign err_count = errcnt_q;

endmodule : imm_encoder
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_encoder
//  Purpose  : Self-checking bench for imm_encoder: a per-cycle reference
//             model of the stream plus hand-computed directed expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        addr_clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = 3'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [4:0]  in_rs1 = 5'd0;
  logic [4:0]  in_rs2 = 5'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [31:0] in_imm = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst;
  logic [9:0]  out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_err    = 0;

  imm_encoder #(
    .Width     (32),
    .AddrWidth (10),
    .BaseAddr  (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr_clr  (addr_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoder: builds the word from field arithmetic and checks
  // the range with plain integer comparisons. Returns {err, inst}.
  function automatic logic [32:0] model_enc(input int fmt, input int rd, input int rs1,
                                            input int rs2, input int f3, input logic [31:0] imm);
    longint      v;
    logic [31:0] u;
    logic [31:0] w;
    logic        e;
    v = longint'($signed(imm));
    u = imm;
    w = 0;
    e = 1'b0;
    case (fmt)
      0, 1, 2: begin
        w = ((u & 32'hFFF) << 20) | (rs1 << 15) | ((fmt == 2 ? 0 : f3) << 12) | (rd << 7)
            | (fmt == 0 ? 32'h13 : fmt == 1 ? 32'h03 : 32'h67);
        e = (v < -2048) || (v > 2047);
      end
      3: begin
        w = (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
            | ((u & 32'h1F) << 7) | 32'h23;
        e = (v < -2048) || (v > 2047);
      end
      4: begin
        w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
            | (f3 << 12) | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
        e = (v < -4096) || (v > 4094) || (v % 2 != 0);
      end
      5: begin
        w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20)
            | (((u >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
        e = (v < -1048576) || (v > 1048574) || (v % 2 != 0);
      end
      default: begin
        w = 0;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  // Model of the presented stream, updated once per cycle.
  logic        m_valid = 1'b0;
  logic [31:0] m_inst  = 32'd0;
  logic        m_err   = 1'b0;
  int          m_addr  = 0;
  int          m_cnt   = 0;

  always @(negedge clk) begin
    logic        ihs, ohs;
    logic [32:0] r;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_inst  = 32'd0;
      m_err   = 1'b0;
      m_addr  = 0;
      m_cnt   = 0;
    end else begin
      check("mon_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("mon_in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
      check("mon_addr", {22'd0, out_addr}, m_addr);
      check("mon_err_count", {24'd0, err_count}, m_cnt);
      if (m_valid) begin
        check("mon_inst", out_inst, m_inst);
        check("mon_err", {31'd0, out_err}, {31'd0, m_err});
      end
      ihs = in_valid && (!m_valid || out_ready);
      ohs = m_valid && out_ready;
      if (ohs && m_err && m_cnt < 255) m_cnt = m_cnt + 1;
      if (addr_clr) m_addr = 0;
      else if (ohs) m_addr = (m_addr + 4) % 1024;
      if (ihs) begin
        r       = model_enc(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm);
        m_inst  = r[31:0];
        m_err   = r[32];
        m_valid = 1'b1;
      end else if (ohs) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int fmt, input int rd, input int rs1, input int rs2,
                       input int f3, input logic [31:0] imm);
    in_fmt    = fmt[2:0];
    in_rd     = rd[4:0];
    in_rs1    = rs1[4:0];
    in_rs2    = rs2[4:0];
    in_funct3 = f3[2:0];
    in_imm    = imm;
    in_valid  = 1'b1;
  endtask

  // Present a word and advance until it has been accepted (bounded).
  task automatic send(input int fmt, input int rd, input int rs1, input int rs2,
                      input int f3, input logic [31:0] imm);
    int n;
    drive(fmt, rd, rs1, rs2, f3, imm);
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    step();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    addr_clr = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_inst", out_inst, 32'd0);
    check("rst_err", {31'd0, out_err}, 32'd0);
    check("rst_addr", {22'd0, out_addr}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    // Basic I-ALU: addi x1, x0, -1
    do_reset();
    out_ready = 1'b1;
    drive(0, 1, 0, 0, 0, 32'hFFFF_FFFF);
    step();
    in_valid = 1'b0;
    check("addi_valid", {31'd0, out_valid}, 32'd1);
    check("addi_inst", out_inst, 32'hFFF0_0093);
    check("addi_addr", {22'd0, out_addr}, 32'h000);
    check("addi_err", {31'd0, out_err}, 32'd0);
    step();

    // S then B back-to-back, full throughput
    do_reset();
    out_ready = 1'b1;
    drive(3, 0, 3, 2, 2, 32'd8);
    check("sb_ready0", {31'd0, in_ready}, 32'd1);
    step();
    check("s_inst", out_inst, 32'h0021_A423);
    check("s_addr", {22'd0, out_addr}, 32'h000);
    drive(4, 0, 0, 0, 0, 32'hFFFF_FFFC);
    check("sb_ready1", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("b_inst", out_inst, 32'hFE00_0EE3);
    check("b_addr", {22'd0, out_addr}, 32'h004);
    step();

    // Backpressure on a J word
    do_reset();
    out_ready = 1'b0;
    drive(5, 1, 0, 0, 0, 32'd2048);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("hold_inst", out_inst, 32'h0010_00EF);
      check("hold_ready", {31'd0, in_ready}, 32'd0);
      check("hold_addr", {22'd0, out_addr}, 32'h000);
      step();
    end
    out_ready = 1'b1;
    step();
    check("release_addr", {22'd0, out_addr}, 32'h004);
    check("release_valid", {31'd0, out_valid}, 32'd0);

    // Error words and saturation
    do_reset();
    out_ready = 1'b1;
    send(4, 0, 0, 0, 0, 32'd3);
    check("e1_err", {31'd0, out_err}, 32'd1);
    check("e1_inst", out_inst, 32'h0000_0163);
    send(0, 0, 0, 0, 0, 32'd2048);
    check("e2_err", {31'd0, out_err}, 32'd1);
    check("e2_inst", out_inst, 32'h8000_0013);
    check("e_cnt1", {24'd0, err_count}, 32'd1);
    send(7, 5, 5, 5, 5, 32'd0);
    check("e3_err", {31'd0, out_err}, 32'd1);
    check("e3_inst", out_inst, 32'd0);
    check("e_cnt2", {24'd0, err_count}, 32'd2);
    in_valid = 1'b0;
    step();
    check("e_cnt3", {24'd0, err_count}, 32'd3);
    for (int i = 0; i < 297; i++) send(7, 0, 0, 0, 0, 32'd0);
    in_valid = 1'b0;
    step();
    check("e_cnt_sat", {24'd0, err_count}, 32'd255);

    // addr_clr coincident with the handshake of the word at 0x3FC
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) send(0, i % 32, 0, 0, 0, i);
    check("clr_pre_addr", {22'd0, out_addr}, 32'h3FC);
    drive(0, 2, 0, 0, 0, 32'd7);
    addr_clr = 1'b1;
    step();
    addr_clr = 1'b0;
    in_valid = 1'b0;
    check("clr_addr", {22'd0, out_addr}, 32'h000);
    check("clr_valid", {31'd0, out_valid}, 32'd1);
    step();

    // Natural wrap after 256 words
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) send(3, 0, i % 32, (i + 1) % 32, i % 8, i);
    check("wrap_pre_addr", {22'd0, out_addr}, 32'h3FC);
    send(1, 3, 4, 0, 2, 32'hFFFF_F800);
    in_valid = 1'b0;
    check("wrap_addr", {22'd0, out_addr}, 32'h000);
    check("lw_inst", out_inst, 32'h8002_2183);
    step();

    // Reset while a word is held under backpressure
    do_reset();
    out_ready = 1'b1;
    send(7, 0, 0, 0, 0, 32'd0);
    send(7, 0, 0, 0, 0, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    check("mid_pre_cnt", {24'd0, err_count}, 32'd1);
    check("mid_pre_addr", {22'd0, out_addr}, 32'h004);
    rst_n = 1'b0;
    #1;
    check("mid_valid", {31'd0, out_valid}, 32'd0);
    check("mid_addr", {22'd0, out_addr}, 32'h000);
    check("mid_cnt", {24'd0, err_count}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_imm_encoder
`default_nettype wire
